// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the program/data RAM port arbiter.
//   RAM_ADDR_W / RAM_DATA_W : RAM geometry, also used by the CPU side
//   M0 / M1                 : master indices (CPU port, loader/debug/DMA port)
//   arb_state_t             : arbiter FSM encoding
//   rd_tag_t                : tag of the read whose data returns next cycle
package ram_port_arbiter_pkg;

  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DATA_W = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic vld;
    logic idx;
  } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and the RAM.
//   mX_req/lock/we/addr/wdata : master X access request
//   mX_gnt/rdata/rvalid       : arbiter response to master X
//   wrEn/addr_toRAM/data_toRAM: arbiter -> RAM
//   data_fromRAM              : RAM -> arbiter, one cycle after the address
// Modports: slave = arbiter side, master = requesters + RAM side.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);
  logic              m0_req, m0_lock, m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt, m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req, m1_lock, m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              wrEn;
  logic [ADDR_W-1:0] addr_toRAM;
  logic [DATA_W-1:0] data_toRAM;
  logic [DATA_W-1:0] data_fromRAM;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata, m0_rvalid,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata, m1_rvalid,
    output wrEn, addr_toRAM, data_toRAM,
    input  data_fromRAM
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata, m0_rvalid,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  wrEn, addr_toRAM, data_toRAM,
    output data_fromRAM
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-input round-robin picker, purely combinational.
//   req  : request bits, [0] = master 0, [1] = master 1
//   last : index of the master granted most recently
//   gnt  : one-hot grant; on a tie the master other than `last` wins
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port program/data RAM between the CPU port (master 0)
// and the loader/debug/DMA port (master 1). One access per cycle,
// round-robin on contention, optional lock for read-modify-write bounded
// by MAX_LOCK consecutive grants.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ram_port_arbiter_if.slave (master requests/responses, RAM side)
// Grants are combinational from req; read data returns one cycle later.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);

  localparam logic [8:0] MAX_LOCK_V = 9'(MAX_LOCK);
  localparam bit         LOCK_EN    = (MAX_LOCK > 1);

  arb_state_t fsm, fsm_nxt;
  logic       last_gnt, last_nxt;
  logic [7:0] lock_cnt, cnt_nxt;
  rd_tag_t    rd_tag, rd_tag_nxt;

  logic [1:0]             req, lock, we, pick, gnt;
  logic [1:0][ADDR_W-1:0] addr_v;
  logic [1:0][DATA_W-1:0] wdata_v;
  logic                   own, sel;
  logic [8:0]             cnt_inc;

  assign req     = {bus.m1_req,   bus.m0_req};
  assign lock    = {bus.m1_lock,  bus.m0_lock};
  assign we      = {bus.m1_we,    bus.m0_we};
  assign addr_v  = {bus.m1_addr,  bus.m0_addr};
  assign wdata_v = {bus.m1_wdata, bus.m0_wdata};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_gnt),
    .gnt  (pick)
  );

  assign cnt_inc = {1'b0, lock_cnt} + 9'd1;

  // Next state / grant. Nothing is granted while rst is high, which also
  // keeps a write from reaching the RAM in the reset cycle.
  always_comb begin
    gnt      = 2'b00;
    fsm_nxt  = fsm;
    last_nxt = last_gnt;
    cnt_nxt  = lock_cnt;
    own      = (fsm == LOCK1);
    if (!rst) begin
      case (fsm)
        ARB: begin
          gnt = pick;
          if (|pick) begin
            last_nxt = pick[1];
            if (LOCK_EN && lock[pick[1]]) begin
              fsm_nxt = pick[1] ? LOCK1 : LOCK0;
              cnt_nxt = 8'd1;
            end
          end
        end
        LOCK0, LOCK1: begin
          // The owner keeps last_gnt on release so a waiting peer wins the tie.
          last_nxt = own;
          if (req[own]) begin
            gnt[own] = 1'b1;
            cnt_nxt  = (lock_cnt == 8'hFF) ? 8'hFF : lock_cnt + 8'd1;
            if (!(lock[own] && cnt_inc < MAX_LOCK_V)) begin
              fsm_nxt = ARB;
              cnt_nxt = 8'd0;
            end
          end else begin
            // Owner went idle: the cycle is simply dropped.
            fsm_nxt = ARB;
            cnt_nxt = 8'd0;
          end
        end
        default: fsm_nxt = ARB;
      endcase
    end
  end

  // RAM side mux: zeros when idle.
  assign sel = gnt[1];

  always_comb begin
    bus.wrEn       = 1'b0;
    bus.addr_toRAM = '0;
    bus.data_toRAM = '0;
    rd_tag_nxt     = '0;
    if (|gnt) begin
      bus.wrEn       = we[sel];
      bus.addr_toRAM = addr_v[sel];
      bus.data_toRAM = wdata_v[sel];
      rd_tag_nxt.vld = !we[sel];
      rd_tag_nxt.idx = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= ARB;
      last_gnt <= M1;
      lock_cnt <= 8'd0;
      rd_tag   <= '0;
    end else begin
      fsm      <= fsm_nxt;
      last_gnt <= last_nxt;
      lock_cnt <= cnt_nxt;
      rd_tag   <= rd_tag_nxt;
    end
  end

  logic rv0, rv1;
  assign rv0 = !rst && rd_tag.vld && (rd_tag.idx == M0);
  assign rv1 = !rst && rd_tag.vld && (rd_tag.idx == M1);

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rv0;
  assign bus.m1_rvalid = rv1;
  assign bus.m0_rdata  = rv0 ? bus.data_fromRAM : '0;
  assign bus.m1_rdata  = rv1 ? bus.data_fromRAM : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // RAM environment model: synchronous write, registered read.
  // Word i initially holds 32'hA5A5_0000 | i.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A5_0000 | 32'(i);
  end
  always @(posedge clk) begin
    if (bus.wrEn) mem[bus.addr_toRAM] <= bus.data_toRAM;
    ram_q <= mem[bus.addr_toRAM];
  end
  assign bus.data_fromRAM = ram_q;

  typedef struct {
    int            id;
    logic          g0, g1, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          rv0, rv1;
    logic [DW-1:0] rd0, rd1;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   row   = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_mis++;
      $display("FAIL row %0d %s: got %h expected %h", id, nm, act, ex);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.id, "m0_gnt",     32'(bus.m0_gnt),     32'(e.g0));
        chk(e.id, "m1_gnt",     32'(bus.m1_gnt),     32'(e.g1));
        chk(e.id, "wrEn",       32'(bus.wrEn),       32'(e.we));
        chk(e.id, "addr_toRAM", 32'(bus.addr_toRAM), 32'(e.addr));
        chk(e.id, "data_toRAM", bus.data_toRAM,      e.wd);
        chk(e.id, "m0_rvalid",  32'(bus.m0_rvalid),  32'(e.rv0));
        chk(e.id, "m1_rvalid",  32'(bus.m1_rvalid),  32'(e.rv1));
        chk(e.id, "m0_rdata",   bus.m0_rdata,        e.rd0);
        chk(e.id, "m1_rdata",   bus.m1_rdata,        e.rd1);
      end
    end
  end

  // One cycle of stimulus plus its hand-computed expected response.
  // Expected RAM outputs follow from the expected grant and the inputs.
  task automatic step(
    input logic r, input logic r0, input logic l0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic l1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic eg0, input logic eg1, input logic erv0, input logic erv1,
    input logic [DW-1:0] erd0, input logic [DW-1:0] erd1);
    exp_t e;
    rst = r;
    bus.m0_req = r0; bus.m0_lock = l0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_lock = l1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
    row++;
    e.id = row; e.g0 = eg0; e.g1 = eg1;
    e.we = 1'b0; e.addr = '0; e.wd = '0;
    if (eg0) begin e.we = w0; e.addr = a0; e.wd = d0; end
    if (eg1) begin e.we = w1; e.addr = a1; e.wd = d1; end
    e.rv0 = erv0; e.rv1 = erv1; e.rd0 = erd0; e.rd1 = erd1;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic r, input logic erv0, input logic erv1,
                      input logic [DW-1:0] erd0, input logic [DW-1:0] erd1);
    step(r, 0,0,0,'0,'0, 0,0,0,'0,'0, 0,0, erv0,erv1, erd0,erd1);
  endtask

  initial begin
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    @(posedge clk); #1;

    // Reset then idle; a write requested during reset must not reach the RAM.
    idle(1, 0,0, 0,0);
    step(1, 1,0,1,14'h0007,32'h1111_1111, 0,0,0,'0,'0, 0,0, 0,0, 0,0);
    idle(0, 0,0, 0,0);

    // Single master: m1 write then read back.
    step(0, 0,0,0,'0,'0, 1,0,1,14'h0040,32'hDEADBEEF, 0,1, 0,0, 0,0);
    step(0, 0,0,0,'0,'0, 1,0,0,14'h0040,'0,           0,1, 0,0, 0,0);
    idle(0, 0,1, 0,32'hDEADBEEF);

    // Contention: both read for 6 cycles, grants alternate starting with m0.
    step(0, 1,0,0,14'h0001,'0, 1,0,0,14'h0002,'0, 1,0, 0,0, 0,0);
    step(0, 1,0,0,14'h0001,'0, 1,0,0,14'h0002,'0, 0,1, 1,0, 32'hA5A50001,0);
    step(0, 1,0,0,14'h0001,'0, 1,0,0,14'h0002,'0, 1,0, 0,1, 0,32'hA5A50002);
    step(0, 1,0,0,14'h0001,'0, 1,0,0,14'h0002,'0, 0,1, 1,0, 32'hA5A50001,0);
    step(0, 1,0,0,14'h0001,'0, 1,0,0,14'h0002,'0, 1,0, 0,1, 0,32'hA5A50002);
    step(0, 1,0,0,14'h0001,'0, 1,0,0,14'h0002,'0, 0,1, 1,0, 32'hA5A50001,0);
    idle(0, 0,1, 0,32'hA5A50002);

    // Lock within limit: m0 locked read then unlocked write; m1 waits, then
    // reads the freshly written word.
    step(0, 1,1,0,14'h0010,'0,           1,0,0,14'h0010,'0, 1,0, 0,0, 0,0);
    step(0, 1,0,1,14'h0010,32'h12345678, 1,0,0,14'h0010,'0, 1,0, 1,0, 32'hA5A50010,0);
    step(0, 0,0,0,'0,'0,                 1,0,0,14'h0010,'0, 0,1, 0,0, 0,0);
    idle(0, 0,1, 0,32'h12345678);

    // Lock limit (MAX_LOCK = 4): m0 holds req+lock 10 cycles, m1 requests.
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 1,0, 0,0, 0,0);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 1,0, 1,0, 32'hA5A50003,0);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 1,0, 1,0, 32'hA5A50003,0);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 1,0, 1,0, 32'hA5A50003,0);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 0,1, 1,0, 32'hA5A50003,0);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 1,0, 0,1, 0,32'hA5A50004);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 1,0, 1,0, 32'hA5A50003,0);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 1,0, 1,0, 32'hA5A50003,0);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 1,0, 1,0, 32'hA5A50003,0);
    step(0, 1,1,0,14'h0003,'0, 1,0,0,14'h0004,'0, 0,1, 1,0, 32'hA5A50003,0);
    idle(0, 0,1, 0,32'hA5A50004);

    // Reset mid-lock: m1 locked with a read in flight, m0 blocked.
    step(0, 0,0,0,'0,'0,       1,1,0,14'h0006,'0, 0,1, 0,0, 0,0);
    step(0, 1,0,0,14'h0005,'0, 1,1,0,14'h0006,'0, 0,1, 0,1, 0,32'hA5A50006);
    step(1, 1,0,0,14'h0005,'0, 1,1,0,14'h0006,'0, 0,0, 0,0, 0,0);
    step(0, 1,0,0,14'h0005,'0, 1,0,0,14'h0006,'0, 1,0, 0,0, 0,0);
    idle(0, 1,0, 32'hA5A50005,0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
